// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
// Multi-cycle MIPS control unit: fetch/decode/execute/memory/write-back sequencing with memory handshake.
// Optional CTRL_ILLEGAL_TRAP_EN: an illegal opcode halts the machine until reset instead of acting as a NOP.
module multicycle_controller #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW  = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SW  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_AND = OP_W'(5);
  localparam logic [OP_W-1:0] OP_OR  = OP_W'(7);

  state_t              state_q, state_n;
  logic [OP_W-1:0]     op_q, op_n;
  logic                ill_n;
  logic                reg_dst_n, reg_write_n, alu_src_n, mem_read_n, mem_write_n, mem_to_reg_n;
  logic [ALUOP_W-1:0]  alu_op_n;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_LW)  || (op == OP_SW);
  endfunction

  function automatic logic is_mem(input logic [OP_W-1:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_dec(input logic [OP_W-1:0] op);
    logic [ALUOP_W-1:0] r;
    r = '0;
    if (op == OP_SUB) r = ALUOP_W'(1);
    if (op == OP_AND) r = ALUOP_W'(2);
    if (op == OP_OR)  r = ALUOP_W'(3);
    return r;
  endfunction

  // Next state, next op_q/illegal, and Moore outputs decoded from the state being entered
  always_comb begin
    state_n      = state_q;
    op_n         = op_q;
    ill_n        = illegal;
    reg_dst_n    = 1'b0;
    reg_write_n  = 1'b0;
    alu_src_n    = 1'b0;
    mem_read_n   = 1'b0;
    mem_write_n  = 1'b0;
    mem_to_reg_n = 1'b0;
    alu_op_n     = '0;

    case (state_q)
      S_IDLE:   state_n = S_FETCH;
      S_FETCH:  if (mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        op_n = opcode;
        if (is_legal(opcode)) begin
          state_n = S_EXEC;
        end else begin
          ill_n = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_n = S_HALT;
`else
          state_n = S_FETCH;
`endif
        end
      end
      S_EXEC:   state_n = is_mem(op_q) ? S_MEM : S_WB;
      S_MEM:    if (mem_ready) state_n = (op_q == OP_SW) ? S_FETCH : S_WB;
      S_WB:     state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      default:  state_n = S_IDLE;
    endcase

    case (state_n)
      S_FETCH: mem_read_n = 1'b1;
      S_EXEC: begin
        alu_op_n  = alu_dec(op_n);
        alu_src_n = is_mem(op_n);
      end
      S_MEM: begin
        alu_src_n   = 1'b1;
        mem_read_n  = (op_n == OP_LW);
        mem_write_n = (op_n == OP_SW);
      end
      S_WB: begin
        reg_write_n  = 1'b1;
        reg_dst_n    = (op_n != OP_LW);
        mem_to_reg_n = (op_n == OP_LW);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      illegal    <= 1'b0;
      reg_dst    <= 1'b0;
      reg_write  <= 1'b0;
      alu_src    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_op     <= '0;
    end else begin
      state_q    <= state_n;
      op_q       <= op_n;
      illegal    <= ill_n;
      reg_dst    <= reg_dst_n;
      reg_write  <= reg_write_n;
      alu_src    <= alu_src_n;
      mem_read   <= mem_read_n;
      mem_write  <= mem_write_n;
      mem_to_reg <= mem_to_reg_n;
      alu_op     <= alu_op_n;
    end
  end

  // PC/IR load is Mealy on the fetch handshake
  assign pc_write = (state_q == S_FETCH) && mem_ready;
  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
`timescale 1ns/1ps
// Bench for multicycle_controller: per-instruction cycle plan model, per-cycle compare, literal pins.
module tb_multicycle_controller;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, rdst, rw, asrc, mr, mw, m2r;
    logic [1:0] aop;
    logic       ill;
  } exp_t;

  localparam logic [5:0] ADD = 6'd1, LW = 6'd2, SUB = 6'd3, SW = 6'd4, AND_ = 6'd5, OR_ = 6'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, ir_write, reg_dst, reg_write, alu_src, mem_read, mem_write, mem_to_reg;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic       illegal;

  logic [7:0] opcode2;
  logic       pcw2, irw2, rdst2, rw2, asrc2, mr2, mw2, m2r2, ill2;
  logic [3:0] aop2;
  logic [2:0] st2;

  int checks = 0;
  int failures = 0;
  bit sticky = 1'b0;
  exp_t exp_q[$];
  exp_t hist[$];
  exp_t ce, co;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_op(alu_op), .state(state), .illegal(illegal)
  );

  multicycle_controller #(.OP_W(8), .ALUOP_W(4)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode2), .mem_ready(mem_ready),
    .pc_write(pcw2), .ir_write(irw2), .reg_dst(rdst2), .reg_write(rw2),
    .alu_src(asrc2), .mem_read(mr2), .mem_write(mw2), .mem_to_reg(m2r2),
    .alu_op(aop2), .state(st2), .illegal(ill2)
  );

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic bit m_legal(input logic [5:0] op);
    return op inside {ADD, SUB, AND_, OR_, LW, SW};
  endfunction

  function automatic logic [1:0] m_alu(input logic [5:0] op);
    case (op)
      SUB:     return 2'd1;
      AND_:    return 2'd2;
      OR_:     return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.ill = sticky;
    return e;
  endfunction

  // One clock cycle of stimulus together with the expected outputs for that cycle
  task automatic step(input logic rdy, input logic [5:0] opc, input exp_t e);
    @(posedge clk); #1;
    mem_ready = rdy;
    opcode = opc;
    exp_q.push_back(e);
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    mem_ready = 1'b1;
    exp_q.push_back(mk(3'd0));
  endtask

  task automatic sync();
    @(negedge clk); #1;
  endtask

  // Plan of one instruction: fw fetch waits, mw memory waits, nr = mem_ready outside handshakes
  task automatic instr(input logic [5:0] op, input int fw, input int mw, input logic nr);
    exp_t e;
    logic [5:0] junk;
    bit ismem;
    junk = ~op;
    ismem = (op == LW) || (op == SW);
    for (int i = 0; i < fw; i++) begin
      e = mk(3'd1); e.mr = 1'b1; step(1'b0, junk, e);
    end
    e = mk(3'd1); e.mr = 1'b1; e.pcw = 1'b1; e.irw = 1'b1; step(1'b1, junk, e);
    e = mk(3'd2); step(nr, op, e);
    if (!m_legal(op)) begin
      sticky = 1'b1;
      return;
    end
    e = mk(3'd3); e.aop = m_alu(op); e.asrc = ismem; step(nr, junk, e);
    if (ismem) begin
      for (int i = 0; i <= mw; i++) begin
        e = mk(3'd4); e.asrc = 1'b1; e.mr = (op == LW); e.mw = (op == SW);
        step((i == mw), junk, e);
      end
    end
    if (op != SW) begin
      e = mk(3'd5); e.rw = 1'b1; e.rdst = (op != LW); e.m2r = (op == LW);
      step(nr, junk, e);
    end
  endtask

  // Per-cycle compare against the planned expectations
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      co.st = state; co.pcw = pc_write; co.irw = ir_write; co.rdst = reg_dst;
      co.rw = reg_write; co.asrc = alu_src; co.mr = mem_read; co.mw = mem_write;
      co.m2r = mem_to_reg; co.aop = alu_op; co.ill = illegal;
      hist.push_back(co);
      chk("state", int'(co.st), int'(ce.st));
      chk("pc_write", int'(co.pcw), int'(ce.pcw));
      chk("ir_write", int'(co.irw), int'(ce.irw));
      chk("reg_dst", int'(co.rdst), int'(ce.rdst));
      chk("reg_write", int'(co.rw), int'(ce.rw));
      chk("alu_src", int'(co.asrc), int'(ce.asrc));
      chk("mem_read", int'(co.mr), int'(ce.mr));
      chk("mem_write", int'(co.mw), int'(ce.mw));
      chk("mem_to_reg", int'(co.m2r), int'(ce.m2r));
      chk("alu_op", int'(co.aop), int'(ce.aop));
      chk("illegal", int'(co.ill), int'(ce.ill));
    end
  end

  // Wide-parameter instance follows the same timing as the first two instructions of the main run
  initial begin
    opcode2 = 8'h07;
    @(posedge reset);
    @(negedge clk); chk("p8_idle_state", int'(st2), 0);
    @(negedge clk); chk("p8_fetch_mem_read", int'(mr2), 1);
    @(negedge clk); chk("p8_decode_state", int'(st2), 2);
    @(negedge clk);
    chk("p8_exec_state", int'(st2), 3);
    chk("p8_exec_alu_op", int'(aop2), 3);
    chk("p8_exec_alu_src", int'(asrc2), 0);
    opcode2 = 8'h87;
    @(negedge clk);
    chk("p8_wb_reg_write", int'(rw2), 1);
    chk("p8_wb_reg_dst", int'(rdst2), 1);
    chk("p8_wb_mem_to_reg", int'(m2r2), 0);
    chk("p8_wb_mem_write", int'(mw2), 0);
    @(negedge clk);
    chk("p8_fetch_pc_write", int'(pcw2), 1);
    chk("p8_fetch_ir_write", int'(irw2), 1);
    @(negedge clk);
    @(negedge clk);
    chk("p8_illegal", int'(ill2), 1);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("p8_halt_state", int'(st2), 6);
`else
    chk("p8_nop_state", int'(st2), 1);
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    int cnt;
    reset = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_illegal", int'(illegal), 0);

    release_reset();
    instr(ADD, 0, 0, 1'b1);
    sync(); n = hist.size();
    chk("add_s0", int'(hist[n-4].st), 1);
    chk("add_s1", int'(hist[n-3].st), 2);
    chk("add_s2", int'(hist[n-2].st), 3);
    chk("add_s3", int'(hist[n-1].st), 5);
    chk("add_exec_alu_op", int'(hist[n-2].aop), 0);
    chk("add_exec_alu_src", int'(hist[n-2].asrc), 0);
    chk("add_wb_reg_write", int'(hist[n-1].rw), 1);
    chk("add_wb_reg_dst", int'(hist[n-1].rdst), 1);
    chk("add_wb_mem_to_reg", int'(hist[n-1].m2r), 0);

    instr(LW, 0, 0, 1'b0);
    instr(SW, 1, 1, 1'b1);
    instr(SUB, 2, 0, 1'b0);
    instr(AND_, 0, 0, 1'b1);
    instr(OR_, 1, 0, 1'b0);

    instr(LW, 0, 2, 1'b1);
    sync(); n = hist.size();
    chk("lw_wait_len_fetch", int'(hist[n-7].st), 1);
    chk("lw_wait_exec", int'(hist[n-5].st), 3);
    cnt = 0;
    for (int i = n - 4; i <= n - 2; i++) if (hist[i].st == 3'd4 && hist[i].mr) cnt++;
    chk("lw_wait_mem_read_cycles", cnt, 3);
    chk("lw_wait_wb_state", int'(hist[n-1].st), 5);
    chk("lw_wait_wb_mem_to_reg", int'(hist[n-1].m2r), 1);
    chk("lw_wait_wb_reg_dst", int'(hist[n-1].rdst), 0);

    instr(SW, 0, 0, 1'b1);
    sync(); n = hist.size();
    chk("sw_fetch", int'(hist[n-4].st), 1);
    chk("sw_mem_state", int'(hist[n-1].st), 4);
    chk("sw_mem_write", int'(hist[n-1].mw), 1);
    cnt = 0;
    for (int i = n - 4; i < n; i++) cnt += int'(hist[i].rw);
    chk("sw_reg_write_count", cnt, 0);

    // Abort a lw while it waits in MEM
    e = mk(3'd1); e.mr = 1'b1; e.pcw = 1'b1; e.irw = 1'b1; step(1'b1, 6'h00, e);
    e = mk(3'd2); step(1'b0, LW, e);
    e = mk(3'd3); e.asrc = 1'b1; step(1'b0, 6'h00, e);
    e = mk(3'd4); e.asrc = 1'b1; e.mr = 1'b1; step(1'b0, 6'h00, e);
    @(posedge clk); #1;
    reset = 1'b0;
    sticky = 1'b0;
    mem_ready = 1'b1;
    exp_q.push_back(mk(3'd0));
    #1;
    chk("abort_state", int'(state), 0);
    chk("abort_mem_read", int'(mem_read), 0);
    chk("abort_alu_src", int'(alu_src), 0);
    step(1'b1, LW, mk(3'd0));
    release_reset();
    instr(LW, 0, 0, 1'b1);
    sync(); n = hist.size();
    chk("post_reset_fetch_state", int'(hist[n-5].st), 1);
    chk("post_reset_fetch_mem_read", int'(hist[n-5].mr), 1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    instr(6'h3F, 0, 0, 1'b1);
    for (int i = 0; i < 12; i++) step(logic'(i % 2), ADD, mk(3'd6));
    sync();
    chk("trap_state", int'(state), 6);
    chk("trap_illegal", int'(illegal), 1);
`else
    instr(6'h3F, 0, 0, 1'b1);
    instr(SUB, 0, 0, 1'b1);
    sync(); n = hist.size();
    chk("nop_decode_state", int'(hist[n-5].st), 2);
    chk("nop_next_fetch", int'(hist[n-4].st), 1);
    chk("nop_sub_alu_op", int'(hist[n-2].aop), 1);
    chk("nop_illegal_sticky", int'(hist[n-1].ill), 1);
    instr(6'h00, 1, 0, 1'b0);
    instr(6'h06, 0, 0, 1'b1);
    instr(LW, 0, 1, 1'b0);
    instr(OR_, 0, 0, 1'b1);
`endif

    sync();
    chk("plan_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
